// File: rtl/imm_materializer.sv
// Turns a 32-bit constant into the RV32I LUI/ADDI words that rebuild it in rd.
// The words leave one at a time through a registered valid/ready stream.
module imm_materializer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] inValue,
    input  logic [4:0]      inRd,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] outInstr,
    output logic            outLast
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_LUI  = 2'd1,
        EMIT_ADDI = 2'd2
    } state_t;

    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_ADDI = 7'b0010011;

    function automatic logic [XLEN-1:0] enc_lui(input logic [19:0] hi20, input logic [4:0] rd);
        return {hi20, rd, OPC_LUI};
    endfunction

    function automatic logic [XLEN-1:0] enc_addi(input logic [11:0] lo12, input logic [4:0] rs1,
                                                 input logic [4:0] rd);
        return {lo12, rs1, 3'b000, rd, OPC_ADDI};
    endfunction

    state_t          state;
    logic            need_pair;
    logic [XLEN-1:0] pending_addi;

    logic [11:0] lo12;
    logic [19:0] hi20;
    logic        fits12;
    logic        lo_zero;
    logic        accept;
    logic        transfer;

    // Adding 0x800 before taking [31:12] only ever carries in value[11],
    // so the sign correction reduces to an increment of the upper bits.
    assign lo12     = inValue[11:0];
    assign hi20     = inValue[31:12] + {19'd0, inValue[11]};
    assign fits12   = (&inValue[31:11]) | ~(|inValue[31:11]);
    assign lo_zero  = ~(|lo12);
    assign inReady  = (state == IDLE);
    assign accept   = inValid & inReady;
    assign transfer = outValid & outReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            need_pair <= 1'b0;
            outValid  <= 1'b0;
            outInstr  <= '0;
            outLast   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        outValid <= 1'b1;
                        if (fits12) begin
                            state     <= EMIT_ADDI;
                            need_pair <= 1'b0;
                            outInstr  <= enc_addi(lo12, 5'd0, inRd);
                            outLast   <= 1'b1;
                        end else begin
                            state     <= EMIT_LUI;
                            need_pair <= ~lo_zero;
                            outInstr  <= enc_lui(hi20, inRd);
                            outLast   <= lo_zero;
                        end
                    end
                end
                EMIT_LUI: begin
                    if (transfer) begin
                        if (need_pair) begin
                            state    <= EMIT_ADDI;
                            outInstr <= pending_addi;
                            outLast  <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            outValid <= 1'b0;
                        end
                    end
                end
                EMIT_ADDI: begin
                    if (transfer) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

    // Second word of a pair is built at accept time, while value/rd are still on the inputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            pending_addi <= enc_addi(lo12, inRd, inRd);
        end
    end

endmodule

// File: tb/tb_imm_materializer.sv
// Self-checking bench for imm_materializer: spec vectors, stalls, reset abort
// and randomized constants against an arithmetic reference model.
module tb_imm_materializer;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] inValue;
    logic [4:0]  inRd;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstr;
    logic        outLast;

    int checks = 0;
    int errors = 0;

    imm_materializer #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .inValue  (inValue),
        .inRd     (inRd),
        .outValid (outValid),
        .outReady (outReady),
        .outInstr (outInstr),
        .outLast  (outLast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] value;
        logic [4:0]  rd;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value = hi*4096 + imm, imm the sign-extended low 12 bits.
    function automatic void model(input logic [31:0] v, input logic [4:0] rd,
                                  output int n, output logic [31:0] w0, output logic [31:0] w1);
        longint sv, lo, imm, hi;
        logic [31:0] lui_w, addi0_w, addi_rd_w;
        sv  = longint'($signed(v));
        lo  = longint'(v) % 4096;
        imm = (lo >= 2048) ? lo - 4096 : lo;
        hi  = (((longint'(v) - imm) + 64'h1_0000_0000) % 64'h1_0000_0000) / 4096;
        lui_w     = 32'(hi * 4096 + longint'(rd) * 128 + 55);
        addi0_w   = 32'(lo * 1048576 + longint'(rd) * 128 + 19);
        addi_rd_w = 32'(lo * 1048576 + longint'(rd) * 32768 + longint'(rd) * 128 + 19);
        if (sv >= -2048 && sv <= 2047) begin
            n = 1; w0 = addi0_w; w1 = 32'h0;
        end else if (lo == 0) begin
            n = 1; w0 = lui_w; w1 = 32'h0;
        end else begin
            n = 2; w0 = lui_w; w1 = addi_rd_w;
        end
    endfunction

    task automatic do_req(input logic [31:0] v, input logic [4:0] rd, input int stall,
                          input int n, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] exp_w;
        logic        exp_l;
        int          t;
        t = 0;
        while (!inReady && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("ready_before_accept", {31'd0, inReady}, 32'd1);
        inValid = 1'b1; inValue = v; inRd = rd;
        @(posedge clk); #1;
        inValid = 1'b0; inValue = $urandom; inRd = 5'($urandom);
        for (int k = 0; k < n; k++) begin
            exp_w = (k == 0) ? w0 : w1;
            exp_l = (k == n - 1);
            chk("word_valid", {31'd0, outValid}, 32'd1);
            for (int s = 0; s < stall; s++) begin
                chk("stall_instr", outInstr, exp_w);
                chk("stall_last", {31'd0, outLast}, {31'd0, exp_l});
                chk("stall_inready", {31'd0, inReady}, 32'd0);
                @(posedge clk); #1;
            end
            chk("word_instr", outInstr, exp_w);
            chk("word_last", {31'd0, outLast}, {31'd0, exp_l});
            chk("busy_inready", {31'd0, inReady}, 32'd0);
            outReady = 1'b1;
            @(posedge clk); #1;
            outReady = 1'b0;
        end
        chk("done_valid", {31'd0, outValid}, 32'd0);
        chk("done_inready", {31'd0, inReady}, 32'd1);
        // An extra offered ready must not pull out a stray word.
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        chk("no_extra_word", {31'd0, outValid}, 32'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] w0, w1, v;
        logic [4:0]  rd;
        logic [31:0] edges[8];

        tbl[0] = '{32'h00000005, 5'd5,  1, 32'h00500293, 32'h0};
        tbl[1] = '{32'h12345000, 5'd10, 1, 32'h12345537, 32'h0};
        tbl[2] = '{32'h12345FFF, 5'd1,  2, 32'h123460B7, 32'hFFF08093};
        tbl[3] = '{32'hFFFFF800, 5'd2,  1, 32'h80000113, 32'h0};
        tbl[4] = '{32'hFFFFFFFF, 5'd2,  1, 32'hFFF00113, 32'h0};

        edges = '{32'h000007FF, 32'h00000800, 32'hFFFFF7FF, 32'h80000000,
                  32'h7FFFFFFF, 32'h7FFFF800, 32'h00000000, 32'hFFFFF000};

        reset = 1'b1; inValid = 1'b0; inValue = '0; inRd = '0; outReady = 1'b0;
        #3;
        chk("reset_valid", {31'd0, outValid}, 32'd0);
        chk("reset_instr", outInstr, 32'd0);
        chk("reset_last", {31'd0, outLast}, 32'd0);
        chk("reset_inready", {31'd0, inReady}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            do_req(tbl[i].value, tbl[i].rd, 0, tbl[i].n, tbl[i].w0, tbl[i].w1);

        // Back-pressure on both words of the pair.
        do_req(tbl[2].value, tbl[2].rd, 3, tbl[2].n, tbl[2].w0, tbl[2].w1);

        // Reset while the LUI of a pair is pending.
        inValid = 1'b1; inValue = 32'h12345FFF; inRd = 5'd1;
        @(posedge clk); #1;
        inValid = 1'b0;
        chk("abort_pending_valid", {31'd0, outValid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_valid", {31'd0, outValid}, 32'd0);
        chk("abort_instr", outInstr, 32'd0);
        chk("abort_last", {31'd0, outLast}, 32'd0);
        chk("abort_inready", {31'd0, inReady}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_stray", {31'd0, outValid}, 32'd0);
            chk("abort_idle_inready", {31'd0, inReady}, 32'd1);
        end
        outReady = 1'b0;
        do_req(tbl[0].value, tbl[0].rd, 0, tbl[0].n, tbl[0].w0, tbl[0].w1);

        for (int i = 0; i < 8; i++) begin
            rd = 5'($urandom);
            model(edges[i], rd, n, w0, w1);
            do_req(edges[i], rd, 0, n, w0, w1);
        end

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: v = $urandom & 32'hFFFFF000;
                default: v = ($urandom & 32'hFFFFF000) | 32'($urandom_range(2040, 2056));
            endcase
            rd = 5'($urandom);
            model(v, rd, n, w0, w1);
            do_req(v, rd, $urandom_range(0, 2), n, w0, w1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
